// File: rtl/iob_mii_loopback_pkg.sv
// ---------------------------------------------------------------------------
// iob_mii_loopback_pkg
//
// Shared definitions for the MII/GMII loopback channel:
//   state_t       ingress FSM state (ST_IDLE = 0, ST_FRAME = 1)
//   SYM_CTRL_W    number of control bits carried next to each symbol (dv, er)
//   sym_rec_w()   width of one {dv, er, data} record in the delay line
// ---------------------------------------------------------------------------
package iob_mii_loopback_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FRAME = 1'b1
    } state_t;

    localparam int SYM_CTRL_W = 2;

    // A delay-line record is the symbol plus its dv and er flags.
    function automatic int sym_rec_w(input int data_w);
        return data_w + SYM_CTRL_W;
    endfunction

endpackage

// File: rtl/iob_mii_loopback_if.sv
// ---------------------------------------------------------------------------
// iob_mii_loopback_if
//
// MII/GMII symbol bundle between a MAC and the loopback channel.
//   tx_data_i / tx_en_i / tx_er_i   MAC transmit side (driven by the MAC)
//   rx_data_o / rx_dv_o / rx_er_o   MAC receive side (driven by the loopback)
// The _i/_o suffixes are as seen from the loopback channel.
// Modports:
//   master  the MAC end (drives tx, observes rx)
//   slave   the loopback end (observes tx, drives rx)
// ---------------------------------------------------------------------------
interface iob_mii_loopback_if #(
    parameter int DATA_W = 4
);

    logic [DATA_W-1:0] tx_data_i;
    logic              tx_en_i;
    logic              tx_er_i;
    logic [DATA_W-1:0] rx_data_o;
    logic              rx_dv_o;
    logic              rx_er_o;

    modport master (
        output tx_data_i, tx_en_i, tx_er_i,
        input  rx_data_o, rx_dv_o, rx_er_o
    );

    modport slave (
        input  tx_data_i, tx_en_i, tx_er_i,
        output rx_data_o, rx_dv_o, rx_er_o
    );

endinterface

// File: rtl/iob_mii_delay.sv
// ---------------------------------------------------------------------------
// iob_mii_delay
//
// DEPTH-stage shift register of WIDTH-bit records with synchronous reset.
// A record presented on d_i in cycle t is visible on q_o in cycle t+DEPTH.
//   clk_i     clock, all state on the rising edge
//   rst_i     synchronous active-high reset, clears every stage
//   d_i       record entering the first stage
//   q_o       record leaving the last stage
//   stages_o  every stage, so the parent can inspect what is in flight
// ---------------------------------------------------------------------------
module iob_mii_delay #(
    parameter int WIDTH = 6,
    parameter int DEPTH = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [WIDTH-1:0]             d_i,
    output logic [WIDTH-1:0]             q_o,
    output logic [DEPTH-1:0][WIDTH-1:0]  stages_o
);

    logic [DEPTH-1:0][WIDTH-1:0] stages;

    // Stage 0 takes the new record, every other stage takes its predecessor.
    // Written as a loop so DEPTH=1 degenerates cleanly to a single register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stages <= '0;
        end else begin
            stages[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q_o      = stages[DEPTH-1];
    assign stages_o = stages;

endmodule

// File: rtl/iob_mii_loopback.sv
// ---------------------------------------------------------------------------
// iob_mii_loopback
//
// Parametrised MII/GMII loopback channel. Transmit symbols are returned to
// the MAC receive side DELAY cycles later. Each frame may be dropped whole or
// have one symbol XOR-corrupted; forwarded/dropped frames and the length of
// the last frame are counted.
//
// Parameters:
//   DATA_W  symbol width (4 = MII nibble, 8 = GMII byte)
//   DELAY   loopback latency in cycles, legal range 1..32
//   CNT_W   width of symbol index, length and statistics counters
//
// Ports:
//   clk_i           eth clock
//   rst_i           synchronous active-high reset
//   mii             slave end of the MII bundle (tx in, rx out)
//   drop_i          drop the frame (sampled on the frame's first cycle)
//   corrupt_en_i    corrupt one symbol (sampled on the first cycle)
//   corrupt_idx_i   index of the symbol to corrupt (sampled on the first cycle)
//   corrupt_mask_i  XOR mask for the corrupted symbol (sampled on the first cycle)
//   frame_cnt_o     forwarded frames, wraps modulo 2^CNT_W
//   drop_cnt_o      dropped frames, wraps modulo 2^CNT_W
//   last_len_o      symbol count of the most recently ended frame
//   busy_o          frame in progress or valid symbols still in the delay line
// ---------------------------------------------------------------------------
module iob_mii_loopback
    import iob_mii_loopback_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DELAY  = 1,
    parameter int CNT_W  = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    iob_mii_loopback_if.slave    mii,
    input  logic                 drop_i,
    input  logic                 corrupt_en_i,
    input  logic [CNT_W-1:0]     corrupt_idx_i,
    input  logic [DATA_W-1:0]    corrupt_mask_i,
    output logic [CNT_W-1:0]     frame_cnt_o,
    output logic [CNT_W-1:0]     drop_cnt_o,
    output logic [CNT_W-1:0]     last_len_o,
    output logic                 busy_o
);

    localparam int             REC_W   = sym_rec_w(DATA_W);
    localparam logic [CNT_W-1:0] IDX_MAX = {CNT_W{1'b1}};

    state_t              state;
    state_t              state_nxt;
    logic                first_cyc;
    logic                frame_end;

    logic [CNT_W-1:0]    index_q;
    logic                drop_q;
    logic                cor_en_q;
    logic [CNT_W-1:0]    cor_idx_q;
    logic [DATA_W-1:0]   cor_mask_q;

    logic [CNT_W-1:0]    cur_idx;
    logic                cur_drop;
    logic                cur_cor_en;
    logic [CNT_W-1:0]    cur_cor_idx;
    logic [DATA_W-1:0]   cur_mask;
    logic                cur_hit;

    logic [REC_W-1:0]             stage_in;
    logic [REC_W-1:0]             stage_out;
    logic [DELAY-1:0][REC_W-1:0]  stages;

    // Ingress FSM state register. Reset always returns to IDLE, which is what
    // makes a still-high tx_en_i after reset start a fresh frame.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ingress FSM next state: a frame is any unbroken run of tx_en_i.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (mii.tx_en_i)  state_nxt = ST_FRAME;
            ST_FRAME: if (!mii.tx_en_i) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Ingress FSM outputs: the first-cycle strobe latches the per-frame
    // controls, the end strobe (tx_en_i falling) updates the statistics.
    always_comb begin
        first_cyc = 1'b0;
        frame_end = 1'b0;
        case (state)
            ST_IDLE:  first_cyc = mii.tx_en_i;
            ST_FRAME: frame_end = !mii.tx_en_i;
            default:  ;
        endcase
    end

    // On the first cycle the latched controls are not yet loaded, so the live
    // inputs are used directly; afterwards only the latched copies count,
    // which is why mid-frame changes on drop_i/corrupt_* have no effect.
    always_comb begin
        cur_idx     = first_cyc ? '0             : index_q;
        cur_drop    = first_cyc ? drop_i         : drop_q;
        cur_cor_en  = first_cyc ? corrupt_en_i   : cor_en_q;
        cur_cor_idx = first_cyc ? corrupt_idx_i  : cor_idx_q;
        cur_mask    = first_cyc ? corrupt_mask_i : cor_mask_q;
        cur_hit     = cur_cor_en && (cur_idx == cur_cor_idx);
    end

    // Per-frame control latch, loaded only on the frame's first cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            drop_q     <= 1'b0;
            cor_en_q   <= 1'b0;
            cor_idx_q  <= '0;
            cor_mask_q <= '0;
        end else if (first_cyc) begin
            drop_q     <= drop_i;
            cor_en_q   <= corrupt_en_i;
            cor_idx_q  <= corrupt_idx_i;
            cor_mask_q <= corrupt_mask_i;
        end
    end

    // Symbol index: holds the index of the next symbol, which at frame end is
    // the frame length. It saturates instead of wrapping so a long frame can
    // never reach the corruption index a second time.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            index_q <= '0;
        end else if (mii.tx_en_i) begin
            index_q <= (cur_idx == IDX_MAX) ? cur_idx : cur_idx + CNT_W'(1);
        end
    end

    // Statistics, updated in the cycle tx_en_i falls so they are visible one
    // cycle later. A frame cut short by reset never reaches this point and so
    // is never counted.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt_o <= '0;
            drop_cnt_o  <= '0;
            last_len_o  <= '0;
        end else if (frame_end) begin
            last_len_o <= index_q;
            if (drop_q) begin
                drop_cnt_o <= drop_cnt_o + CNT_W'(1);
            end else begin
                frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            end
        end
    end

    // Record entering the delay line. Idle cycles and dropped frames insert an
    // all-zero record so the receive side sees clean idle.
    always_comb begin
        stage_in = '0;
        if (mii.tx_en_i && !cur_drop) begin
            stage_in = {1'b1, mii.tx_er_i,
                        mii.tx_data_i ^ (cur_hit ? cur_mask : DATA_W'(0))};
        end
    end

    iob_mii_delay #(
        .WIDTH (REC_W),
        .DEPTH (DELAY)
    ) u_delay (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .d_i      (stage_in),
        .q_o      (stage_out),
        .stages_o (stages)
    );

    assign mii.rx_dv_o   = stage_out[REC_W-1];
    assign mii.rx_er_o   = stage_out[REC_W-2];
    assign mii.rx_data_o = stage_out[DATA_W-1:0];

    // Busy while a frame is being received or any valid symbol is still
    // travelling through the delay line.
    always_comb begin
        busy_o = (state == ST_FRAME);
        for (int i = 0; i < DELAY; i++) begin
            busy_o = busy_o | stages[i][REC_W-1];
        end
    end

endmodule

// File: tb/tb_iob_mii_loopback.sv
// ---------------------------------------------------------------------------
// tb_iob_mii_loopback
//
// Self-checking bench for iob_mii_loopback (DATA_W=4, DELAY=3, CNT_W=4).
// Stimulus pushes each expected receive symbol, tagged with the cycle it must
// appear in, onto a queue; a monitor pops and compares every cycle. Frame
// statistics and busy are predicted from a per-cycle history of what was
// driven.
// ---------------------------------------------------------------------------
module tb_iob_mii_loopback;

    localparam int DATA_W  = 4;
    localparam int DELAY   = 3;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int HIST    = 8192;

    typedef struct {
        int                cyc;
        logic [DATA_W-1:0] data;
        logic              er;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               drop_i;
    logic               corrupt_en_i;
    logic [CNT_W-1:0]   corrupt_idx_i;
    logic [DATA_W-1:0]  corrupt_mask_i;
    logic [CNT_W-1:0]   frame_cnt_o;
    logic [CNT_W-1:0]   drop_cnt_o;
    logic [CNT_W-1:0]   last_len_o;
    logic               busy_o;

    exp_t exp_q[$];
    bit   en_h[HIST];
    bit   fwd_h[HIST];
    bit   rst_h[HIST];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   mon_en = 1'b0;
    int   m_frames = 0;
    int   m_drops = 0;
    int   m_last = 0;

    iob_mii_loopback_if #(.DATA_W(DATA_W)) mii ();

    iob_mii_loopback #(
        .DATA_W (DATA_W),
        .DELAY  (DELAY),
        .CNT_W  (CNT_W)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .mii            (mii),
        .drop_i         (drop_i),
        .corrupt_en_i   (corrupt_en_i),
        .corrupt_idx_i  (corrupt_idx_i),
        .corrupt_mask_i (corrupt_mask_i),
        .frame_cnt_o    (frame_cnt_o),
        .drop_cnt_o     (drop_cnt_o),
        .last_len_o     (last_len_o),
        .busy_o         (busy_o)
    );

    always #5 clk = ~clk;

    // Cycle number; stable between edges, so both the driver and the monitor
    // can tag events with it.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic rec(input bit en, input bit fwd, input bit r);
        if (cyc < HIST) begin
            en_h[cyc]  = en;
            fwd_h[cyc] = fwd;
            rst_h[cyc] = r;
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic junk_side();
        drop_i         = 1'($urandom);
        corrupt_en_i   = 1'($urandom);
        corrupt_idx_i  = CNT_W'($urandom);
        corrupt_mask_i = DATA_W'($urandom);
    endtask

    task automatic set_idle();
        mii.tx_en_i   = 1'b0;
        mii.tx_data_i = DATA_W'($urandom);
        mii.tx_er_i   = 1'($urandom);
        junk_side();
    endtask

    // Busy in cycle n: a frame was being transmitted in cycle n-1, or a
    // forwarded symbol sent within the last DELAY cycles has not been wiped
    // by a reset since.
    function automatic bit model_busy(input int n);
        bit b;
        b = 1'b0;
        if (n >= 1 && en_h[n-1] && !rst_h[n-1]) b = 1'b1;
        for (int k = 1; k <= DELAY; k++) begin
            int c = n - k;
            if (c >= 0 && fwd_h[c]) begin
                bit alive = 1'b1;
                for (int j = c; j < n; j++) if (rst_h[j]) alive = 1'b0;
                if (alive) b = 1'b1;
            end
        end
        return b;
    endfunction

    // Anything expected after cycle r never leaves the channel once reset hits.
    task automatic flush_after(input int r);
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc > r)
            void'(exp_q.pop_back());
    endtask

    task automatic stats_check();
        check_output("frame_cnt", frame_cnt_o, m_frames);
        check_output("drop_cnt",  drop_cnt_o,  m_drops);
        check_output("last_len",  last_len_o,  m_last);
    endtask

    // One frame of len symbols followed by gap idle cycles (gap >= 1).
    task automatic apply_stimulus(input int len, input bit rnd, input bit drop,
                                  input bit cor, input int idx,
                                  input logic [DATA_W-1:0] mask,
                                  input int er_pos, input bit er_rand,
                                  input int gap);
        logic [DATA_W-1:0] d;
        logic              e;
        exp_t              x;
        for (int i = 0; i < len; i++) begin
            d = rnd ? DATA_W'($urandom) : DATA_W'(i + 1);
            e = (i == er_pos) || (er_rand && $urandom_range(0, 7) == 0);
            mii.tx_en_i   = 1'b1;
            mii.tx_data_i = d;
            mii.tx_er_i   = e;
            if (i == 0) begin
                drop_i         = drop;
                corrupt_en_i   = cor;
                corrupt_idx_i  = CNT_W'(idx);
                corrupt_mask_i = mask;
            end else begin
                junk_side();
            end
            rec(1'b1, !drop, 1'b0);
            if (!drop) begin
                x.cyc  = cyc + DELAY;
                x.data = (cor && i == idx) ? (d ^ mask) : d;
                x.er   = e;
                exp_q.push_back(x);
            end
            next_cycle();
        end
        set_idle();
        rec(1'b0, 1'b0, 1'b0);
        if (drop) m_drops = (m_drops + 1) % (CNT_MAX + 1);
        else      m_frames = (m_frames + 1) % (CNT_MAX + 1);
        m_last = (len > CNT_MAX) ? CNT_MAX : len;
        next_cycle();
        rec(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        stats_check();
        for (int g = 1; g < gap; g++) begin
            next_cycle();
            set_idle();
            rec(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        set_idle();
        flush_after(cyc);
        m_frames = 0;
        m_drops  = 0;
        m_last   = 0;
        for (int i = 0; i < n; i++) begin
            rec(1'b0, 1'b0, 1'b1);
            next_cycle();
        end
        rst = 1'b0;
        rec(1'b0, 1'b0, 1'b0);
    endtask

    // Every cycle: busy against the history model, then either the symbol
    // due this cycle or a clean idle on the receive side.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check_output("busy", busy_o, model_busy(cyc));
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    check_output("rx_dv",   mii.rx_dv_o,   1);
                    check_output("rx_data", mii.rx_data_o, exp_q[0].data);
                    check_output("rx_er",   mii.rx_er_o,   exp_q[0].er);
                    void'(exp_q.pop_front());
                end else begin
                    check_output("rx_dv_idle",   mii.rx_dv_o,   0);
                    check_output("rx_er_idle",   mii.rx_er_o,   0);
                    check_output("rx_data_idle", mii.rx_data_o, 0);
                end
            end
        end
    endtask

    // Directed scenarios first, then randomized frames, counter wrap and a
    // reset that lands in the middle of a frame.
    initial begin
        logic [DATA_W-1:0] d;
        exp_t              x;

        rst = 1'b1;
        set_idle();
        fork
            monitor();
        join_none
        for (int i = 0; i < 3; i++) begin
            rec(1'b0, 1'b0, 1'b1);
            next_cycle();
        end
        rst = 1'b0;
        rec(1'b0, 1'b0, 1'b0);
        mon_en = 1'b1;
        $display("[TB] reset released at cycle %0d", cyc);

        @(negedge clk);
        check_output("reset_frame_cnt", frame_cnt_o, 0);
        check_output("reset_drop_cnt",  drop_cnt_o,  0);
        check_output("reset_last_len",  last_len_o,  0);
        check_output("reset_busy",      busy_o,      0);
        check_output("reset_rx_dv",     mii.rx_dv_o, 0);
        check_output("reset_rx_data",   mii.rx_data_o, 0);

        apply_stimulus(8, 1'b0, 1'b0, 1'b0, 0, 4'h0, -1, 1'b0, 2);
        check_output("plain_frame_cnt", frame_cnt_o, 1);
        check_output("plain_last_len",  last_len_o,  8);

        apply_stimulus(8, 1'b0, 1'b0, 1'b1, 3, 4'hF, -1, 1'b0, 2);

        apply_stimulus(8, 1'b0, 1'b1, 1'b0, 0, 4'h0, -1, 1'b0, 2);
        check_output("drop_drop_cnt",  drop_cnt_o,  1);
        check_output("drop_frame_cnt", frame_cnt_o, 2);
        check_output("drop_last_len",  last_len_o,  8);

        apply_stimulus(4, 1'b0, 1'b0, 1'b0, 0, 4'h0, 2, 1'b0, 2);
        apply_stimulus(1, 1'b1, 1'b0, 1'b0, 0, 4'h0, -1, 1'b0, 1);
        check_output("len1_last_len", last_len_o, 1);
        apply_stimulus(1, 1'b1, 1'b1, 1'b0, 0, 4'h0, -1, 1'b0, 1);
        apply_stimulus(5, 1'b1, 1'b0, 1'b1, 7, 4'hA, -1, 1'b0, 2);
        apply_stimulus(5, 1'b1, 1'b0, 1'b1, 0, 4'h5, -1, 1'b0, 1);
        apply_stimulus(20, 1'b1, 1'b0, 1'b0, 0, 4'h0, -1, 1'b1, 3);
        check_output("long_last_len_sat", last_len_o, CNT_MAX);

        repeat (40) begin
            apply_stimulus($urandom_range(1, 12), 1'b1,
                           $urandom_range(0, 3) == 0, 1'($urandom),
                           $urandom_range(0, 14), DATA_W'($urandom),
                           -1, 1'b1, $urandom_range(1, 4));
        end

        do_reset(2);
        repeat (17) apply_stimulus(1, 1'b1, 1'b0, 1'b0, 0, 4'h0, -1, 1'b0, 1);
        check_output("wrap_frame_cnt", frame_cnt_o, 1);

        drop_i       = 1'b0;
        corrupt_en_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = DATA_W'($urandom);
            mii.tx_en_i   = 1'b1;
            mii.tx_data_i = d;
            mii.tx_er_i   = 1'b0;
            if (i > 0) junk_side();
            rec(1'b1, 1'b1, 1'b0);
            x.cyc  = cyc + DELAY;
            x.data = d;
            x.er   = 1'b0;
            exp_q.push_back(x);
            next_cycle();
        end
        rst = 1'b1;
        mii.tx_data_i = DATA_W'($urandom);
        rec(1'b1, 1'b0, 1'b1);
        flush_after(cyc);
        m_frames = 0;
        m_drops  = 0;
        m_last   = 0;
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check_output("midrst_frame_cnt", frame_cnt_o, 0);
        check_output("midrst_drop_cnt",  drop_cnt_o,  0);
        check_output("midrst_last_len",  last_len_o,  0);
        check_output("midrst_rx_dv",     mii.rx_dv_o, 0);
        apply_stimulus(6, 1'b1, 1'b0, 1'b0, 0, 4'h0, -1, 1'b0, 2);
        check_output("midrst_new_len",   last_len_o,  6);
        check_output("midrst_new_count", frame_cnt_o, 1);

        for (int i = 0; i < DELAY + 4; i++) begin
            next_cycle();
            set_idle();
            rec(1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        check_output("scoreboard_left", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
